temp_control_fsm: RTL and testbench
===================================

Name: temp_control_fsm

Overview:
- Downstream consumer of TemperatureCalculator: takes each computed signed temperature sample (tempc) and drives the heater and cooler relays of the home system.
- Uses a hysteresis state machine with a minimum-dwell lockout, a sticky over-temperature alarm and a stale-sample watchdog.
- All outputs are registered. The block sits between the temperature datapath and the actuator drivers.

Parameters:
- MIN_DWELL, 1000, clock cycles a state must be held before a hysteresis-driven transition is allowed (≥1).
- TIMEOUT, 100000, consecutive cycles without tempc_valid before samples are declared stale (≥2).
- ALARM_HI, 32'sd900, signed threshold; any sample ≥ ALARM_HI raises the alarm.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- enable  in  1  control enable; low forces IDLE with both actuators off (except in ALARM).
- tempc  in  32  signed two's-complement temperature sample from TemperatureCalculator.
- tempc_valid  in  1  one-cycle strobe; tempc is valid on this cycle.
- setpoint  in  32  signed target temperature; sampled on tempc_valid cycles.
- hyst  in  8  unsigned hysteresis band half-width.
- alarm_clr  in  1  request to leave ALARM.
- heater_on  out  1  heater relay drive.
- cooler_on  out  1  cooler relay drive.
- alarm  out  1  high while in ALARM.
- stale  out  1  watchdog flag, no recent sample.
- state  out  2  current state: IDLE=0, HEAT=1, COOL=2, ALARM=3.
- temp_q  out  32  last accepted sample.

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; heater_on=0, cooler_on=0, alarm=0, stale=0.
  - temp_q=0, dwell counter=0, watchdog counter=0.
- Outputs by state, registered and updated on the same edge as state:
  - IDLE: heater 0, cooler 0.
  - HEAT: heater 1, cooler 0.
  - COOL: heater 0, cooler 1.
  - ALARM: heater 0, cooler 1, alarm 1.
- Arithmetic:
  - Thresholds lo = setpoint − hyst and hi = setpoint + hyst are computed in 33-bit signed. hyst is zero-extended, so there is no wrap at 32-bit extremes.
  - All compares are signed.
- Sample acceptance: on every edge with tempc_valid=1, temp_q ← tempc and the watchdog counter is cleared. Decisions use the incoming tempc on that same edge, giving a latency of one edge from strobe to output.
- Priority on a tempc_valid edge, highest first:
  1. tempc ≥ ALARM_HI: go to ALARM, from any state and regardless of enable or dwell.
  2. state==ALARM: stay in ALARM.
  3. enable=0: go to IDLE.
  4. Dwell counter ≠ 0: hold state.
  5. Hysteresis rules:
     - IDLE: tempc < lo → HEAT; tempc > hi → COOL; otherwise stay.
     - HEAT: tempc ≥ setpoint → IDLE.
     - COOL: tempc ≤ setpoint → IDLE.
- Without tempc_valid:
  - enable=0 forces IDLE, except in ALARM.
  - A watchdog expiry forces IDLE, except in ALARM.
- ALARM exit: alarm_clr=1 with temp_q < ALARM_HI and no tempc_valid on that edge → IDLE. Otherwise alarm_clr is ignored.
- Dwell counter:
  - Loaded with MIN_DWELL−1 on every state change, except changes caused by enable=0, which clear it to 0.
  - Decrements by 1 per cycle, saturating at 0.
- Watchdog:
  - Increments each cycle without tempc_valid, saturating at TIMEOUT.
  - When it reaches TIMEOUT: stale←1 and state forced to IDLE (unless in ALARM).
  - stale clears on the next tempc_valid edge; that sample is evaluated normally.
- Simultaneous events:
  - The watchdog reaching TIMEOUT on the same edge as tempc_valid: valid wins and the counter clears.
  - alarm_clr together with an alarm-level sample: stay in ALARM.
- Reset mid-operation: actuators drop immediately (asynchronous); no state is retained.
- heater_on and cooler_on are never both 1 except in ALARM, where heater is always 0. Both-high is illegal and is asserted in the bench.

Test Plan:
- Bench parameters: MIN_DWELL=4, TIMEOUT=20, ALARM_HI=900, setpoint=220, hyst=10, enable=1.
- Hysteresis: samples 215, 209, 215, 225 spaced ≥5 cycles apart → states IDLE, HEAT (heater_on=1 one edge after the 209 strobe), HEAT, IDLE. Then 231 → COOL; 220 → IDLE.
- Dwell lockout: sample 205 → HEAT; on the next cycle sample 230 → stays HEAT. The same 230 sample 5 cycles later → IDLE.
- Alarm: sample 950 during HEAT on a dwell-locked cycle → ALARM (alarm=1, cooler=1, heater=0). alarm_clr with temp_q=950 → stays ALARM. Sample 500, then alarm_clr → IDLE.
- Watchdog: from COOL, no strobes for 20 cycles → stale=1, state IDLE. Strobe with 205 → stale=0; HEAT after dwell.
- Enable and reset: enable=0 in HEAT → IDLE next edge, dwell cleared. Re-enable with sample 205 → HEAT immediately. Assert rst_n=0 mid-cycle → heater_on=0 without waiting for a clock edge.
- Width extremes: setpoint=32'sh7FFFFFF8, hyst=255, sample 32'sh7FFFFFFF → no COOL (no wrap); signed negative sample −40 with setpoint 220 → HEAT.

Source files
------------

// File: rtl/temp_control_fsm.sv
// Heater/cooler relay controller: hysteresis FSM with dwell lockout,
// sticky over-temperature alarm and stale-sample watchdog.
module temp_control_fsm #(
   parameter int                 MIN_DWELL = 1000,
   parameter int                 TIMEOUT   = 100000,
   parameter logic signed [31:0] ALARM_HI  = 32'sd900
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        enable,
   input  logic [31:0] tempc,
   input  logic        tempc_valid,
   input  logic [31:0] setpoint,
   input  logic [7:0]  hyst,
   input  logic        alarm_clr,
   output logic        heater_on,
   output logic        cooler_on,
   output logic        alarm,
   output logic        stale,
   output logic [1:0]  state,
   output logic [31:0] temp_q
);

   localparam int DW = $clog2(MIN_DWELL + 1);
   localparam int WW = $clog2(TIMEOUT + 1);
   localparam logic [DW-1:0] DWELL_LOAD = DW'(MIN_DWELL - 1);
   localparam logic [WW-1:0] WD_MAX     = WW'(TIMEOUT);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      HEAT  = 2'd1,
      COOL  = 2'd2,
      ALARM = 2'd3
   } state_t;

   state_t          cur;
   state_t          nxt;
   logic            en_drop;
   logic [DW-1:0]   dwell;
   logic [WW-1:0]   wd;
   logic [WW-1:0]   wd_inc;
   logic            expire;
   logic            alarm_hit;
   logic            tq_ok;
   logic signed [32:0] t33;
   logic signed [32:0] sp33;
   logic signed [32:0] h33;
   logic signed [32:0] lo;
   logic signed [32:0] hi;

   // 33-bit thresholds so setpoint +/- hyst cannot wrap
   assign t33  = {tempc[31], tempc};
   assign sp33 = {setpoint[31], setpoint};
   assign h33  = {25'd0, hyst};
   assign lo   = sp33 - h33;
   assign hi   = sp33 + h33;

   assign alarm_hit = $signed(tempc) >= ALARM_HI;
   assign tq_ok     = $signed(temp_q) < ALARM_HI;
   assign wd_inc    = (wd == WD_MAX) ? wd : wd + 1'b1;
   assign expire    = (wd_inc == WD_MAX);

   always_comb begin
      nxt     = cur;
      en_drop = 1'b0;
      if (tempc_valid) begin
         if (alarm_hit) begin
            nxt = ALARM;
         end else if (cur == ALARM) begin
            nxt = ALARM;
         end else if (!enable) begin
            nxt     = IDLE;
            en_drop = 1'b1;
         end else if (dwell != '0) begin
            nxt = cur;
         end else begin
            unique case (cur)
               IDLE: begin
                  if (t33 < lo)
                     nxt = HEAT;
                  else if (t33 > hi)
                     nxt = COOL;
               end
               HEAT: if (t33 >= sp33) nxt = IDLE;
               COOL: if (t33 <= sp33) nxt = IDLE;
               default: nxt = cur;
            endcase
         end
      end else begin
         if (cur == ALARM) begin
            if (alarm_clr && tq_ok)
               nxt = IDLE;
         end else if (!enable) begin
            nxt     = IDLE;
            en_drop = 1'b1;
         end else if (expire) begin
            nxt = IDLE;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cur       <= IDLE;
         dwell     <= '0;
         wd        <= '0;
         stale     <= 1'b0;
         temp_q    <= '0;
         heater_on <= 1'b0;
         cooler_on <= 1'b0;
         alarm     <= 1'b0;
      end else begin
         cur <= nxt;
         if (nxt != cur)
            dwell <= en_drop ? '0 : DWELL_LOAD;
         else if (dwell != '0)
            dwell <= dwell - 1'b1;
         if (tempc_valid) begin
            temp_q <= tempc;
            wd     <= '0;
            stale  <= 1'b0;
         end else begin
            wd <= wd_inc;
            if (expire)
               stale <= 1'b1;
         end
         heater_on <= (nxt == HEAT);
         cooler_on <= (nxt == COOL) || (nxt == ALARM);
         alarm     <= (nxt == ALARM);
      end
   end

   assign state = cur;

endmodule

// File: tb/tb_temp_control_fsm.sv
// Directed plus randomized bench for temp_control_fsm against a
// rule-level reference model.
module tb_temp_control_fsm;

   localparam int MD = 4;
   localparam int TO = 20;
   localparam longint AH = 900;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        enable = 1'b1;
   logic [31:0] tempc = '0;
   logic        tempc_valid = 1'b0;
   logic [31:0] setpoint = 32'd220;
   logic [7:0]  hyst = 8'd10;
   logic        alarm_clr = 1'b0;
   logic        heater_on;
   logic        cooler_on;
   logic        alarm;
   logic        stale;
   logic [1:0]  state;
   logic [31:0] temp_q;

   int checks = 0;
   int errors = 0;

   // reference model: state 0..3, dwell, watchdog, stale, last sample
   int          ms;
   int          md;
   int          mwd;
   bit          mstale;
   logic [31:0] mtq;

   temp_control_fsm #(
      .MIN_DWELL (MD),
      .TIMEOUT   (TO),
      .ALARM_HI  (32'sd900)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .enable      (enable),
      .tempc       (tempc),
      .tempc_valid (tempc_valid),
      .setpoint    (setpoint),
      .hyst        (hyst),
      .alarm_clr   (alarm_clr),
      .heater_on   (heater_on),
      .cooler_on   (cooler_on),
      .alarm       (alarm),
      .stale       (stale),
      .state       (state),
      .temp_q      (temp_q)
   );

   always #5 clk = ~clk;

   task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic void model_reset();
      ms = 0; md = 0; mwd = 0; mstale = 0; mtq = '0;
   endfunction

   function automatic void model_step();
      longint t  = longint'($signed(tempc));
      longint sp = longint'($signed(setpoint));
      longint h  = longint'(hyst);
      int n = ms;
      bit byen = 0;
      if (tempc_valid) begin
         if (t >= AH) n = 3;
         else if (ms == 3) n = 3;
         else if (!enable) begin n = 0; byen = 1; end
         else if (md != 0) n = ms;
         else if (ms == 0 && t < sp - h) n = 1;
         else if (ms == 0 && t > sp + h) n = 2;
         else if (ms == 1 && t >= sp) n = 0;
         else if (ms == 2 && t <= sp) n = 0;
         mwd = 0; mstale = 0; mtq = tempc;
      end else begin
         mwd = (mwd + 1 > TO) ? TO : mwd + 1;
         if (mwd == TO) mstale = 1;
         if (ms == 3) begin
            if (alarm_clr && longint'($signed(mtq)) < AH) n = 0;
         end else if (!enable) begin
            n = 0; byen = 1;
         end else if (mwd == TO) begin
            n = 0;
         end
      end
      if (n != ms) md = byen ? 0 : MD - 1;
      else if (md > 0) md = md - 1;
      ms = n;
   endfunction

   task automatic check_all();
      chk("state", 32'(state), 32'(ms));
      chk("heater", 32'(heater_on), 32'(ms == 1));
      chk("cooler", 32'(cooler_on), 32'(ms == 2 || ms == 3));
      chk("alarm", 32'(alarm), 32'(ms == 3));
      chk("stale", 32'(stale), 32'(mstale));
      chk("temp_q", temp_q, mtq);
      chk("both_on", 32'(heater_on & cooler_on), 32'd0);
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      #1;
      check_all();
   endtask

   task automatic idle(int n);
      repeat (n) tick();
   endtask

   task automatic sample(logic [31:0] t);
      tempc = t;
      tempc_valid = 1'b1;
      tick();
      tempc_valid = 1'b0;
   endtask

   task automatic clr_tick();
      alarm_clr = 1'b1;
      tick();
      alarm_clr = 1'b0;
   endtask

   int gap;

   initial begin
      model_reset();
      #2 rst_n = 1'b0;
      #2;
      chk("rst_state", 32'(state), 32'd0);
      chk("rst_heater", 32'(heater_on), 32'd0);
      chk("rst_cooler", 32'(cooler_on), 32'd0);
      chk("rst_alarm", 32'(alarm), 32'd0);
      chk("rst_stale", 32'(stale), 32'd0);
      chk("rst_temp_q", temp_q, 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      idle(2);
      sample(32'd215);  chk("h215", 32'(state), 32'd0);
      idle(5);
      sample(32'd209);  chk("h209", 32'(state), 32'd1);
      chk("h209_heater", 32'(heater_on), 32'd1);
      idle(5);
      sample(32'd215);  chk("h215b", 32'(state), 32'd1);
      idle(5);
      sample(32'd225);  chk("h225", 32'(state), 32'd0);
      idle(5);
      sample(32'd231);  chk("h231", 32'(state), 32'd2);
      chk("h231_cooler", 32'(cooler_on), 32'd1);
      idle(5);
      sample(32'd220);  chk("h220", 32'(state), 32'd0);
      idle(5);

      sample(32'd205);  chk("d205", 32'(state), 32'd1);
      sample(32'd230);  chk("d230_lock", 32'(state), 32'd1);
      idle(4);
      sample(32'd230);  chk("d230_free", 32'(state), 32'd0);

      idle(4);
      sample(32'd205);  chk("a205", 32'(state), 32'd1);
      sample(32'd950);  chk("a950", 32'(state), 32'd3);
      chk("a950_alarm", 32'(alarm), 32'd1);
      chk("a950_cooler", 32'(cooler_on), 32'd1);
      chk("a950_heater", 32'(heater_on), 32'd0);
      idle(2);
      clr_tick();       chk("a_clr_hot", 32'(state), 32'd3);
      sample(32'd500);  chk("a500", 32'(state), 32'd3);
      clr_tick();       chk("a_clr_ok", 32'(state), 32'd0);
      chk("a_clr_alarm", 32'(alarm), 32'd0);
      idle(5);

      sample(32'd231);  chk("w_cool", 32'(state), 32'd2);
      idle(19);
      chk("w19_stale", 32'(stale), 32'd0);
      chk("w19_state", 32'(state), 32'd2);
      idle(1);
      chk("w20_stale", 32'(stale), 32'd1);
      chk("w20_state", 32'(state), 32'd0);
      sample(32'd205);
      chk("w_strobe_stale", 32'(stale), 32'd0);
      chk("w_strobe_state", 32'(state), 32'd0);
      idle(3);
      sample(32'd205);  chk("w_heat", 32'(state), 32'd1);

      enable = 1'b0;
      tick();           chk("en_off", 32'(state), 32'd0);
      chk("en_off_heater", 32'(heater_on), 32'd0);
      enable = 1'b1;
      sample(32'd205);  chk("en_on", 32'(state), 32'd1);

      #3 rst_n = 1'b0;
      #1;
      chk("arst_heater", 32'(heater_on), 32'd0);
      chk("arst_state", 32'(state), 32'd0);
      chk("arst_temp_q", temp_q, 32'd0);
      model_reset();
      #2 rst_n = 1'b1;

      setpoint = 32'h7FFF_FFF8;
      hyst = 8'd255;
      sample(32'h7FFF_FFFF);
      chk("x_max", 32'(state), 32'd3);
      clr_tick();       chk("x_max_clr", 32'(state), 32'd3);
      sample(32'd100);
      clr_tick();       chk("x_exit", 32'(state), 32'd0);
      idle(4);
      sample(32'd100);  chk("x_hi_nowrap", 32'(state), 32'd1);
      enable = 1'b0;
      tick();
      enable = 1'b1;
      setpoint = 32'h8000_0008;
      sample(32'h8000_0000);
      chk("x_lo_nowrap", 32'(state), 32'd0);
      setpoint = 32'd220;
      hyst = 8'd10;
      idle(1);
      sample(-32'sd40); chk("x_neg", 32'(state), 32'd1);

      gap = 0;
      for (int i = 0; i < 3000; i++) begin
         if (gap == 0 && $urandom_range(0, 149) == 0) gap = 25;
         if (gap > 0) begin
            gap--;
            tempc_valid = 1'b0;
         end else begin
            tempc_valid = ($urandom_range(0, 99) < 25);
         end
         case ($urandom_range(0, 9))
            0: tempc = 32'($urandom_range(850, 1000));
            1: tempc = 32'd0 - 32'($urandom_range(0, 300));
            default: tempc = 32'($urandom_range(180, 260));
         endcase
         enable = ($urandom_range(0, 19) != 0);
         alarm_clr = ($urandom_range(0, 7) == 0);
         if ($urandom_range(0, 49) == 0) hyst = 8'($urandom_range(0, 40));
         if ($urandom_range(0, 49) == 0)
            setpoint = 32'($urandom_range(150, 300));
         tick();
      end
      tempc_valid = 1'b0;
      alarm_clr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
